alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: FIXED_PRIO, default 0; 0 = round-robin between requesters, 1 = requester 0 always wins.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 r0_valid / r1_valid  input  1 each  request pending on port 0 / port 1.
REQ-005 r0_ready / r1_ready  output  1 each  port accepted this cycle (handshake = valid & ready).
REQ-006 r0_ctrl / r1_ctrl  input  2 each  op: 00 add, 01 sub, 10 and, 11 xor.
REQ-007 r0_a, r0_b / r1_a, r1_b  input  64 each  operands.
REQ-008 o_valid  output  1  result register holds an unconsumed result.
REQ-009 o_ready  input  1  consumer accepts the result this cycle.
REQ-010 o_y  output  64  registered result.
REQ-011 o_ovf  output  1  signed overflow; add/sub only, 0 for and/xor.
REQ-012 o_zf / o_sf  output  1 each  o_y == 0 / o_y[63].
REQ-013 o_id  output  1  port that issued the result.

Function
REQ-014 One shared combinational 64-bit ALU; arbiter selects the granted port's ctrl/a/b onto it.
REQ-015 ALU results: add y=a+b; sub y=a-b; and y=a&b; xor y=a^b; all modulo 2^64.
REQ-016 Overflow: add: a[63]==b[63] && y[63]!=a[63]; sub: a[63]!=b[63] && y[63]!=a[63].
REQ-017 FSM states: EMPTY (o_valid=0), FULL (o_valid=1).
REQ-018 Output register can load when state is EMPTY, or state is FULL and o_ready=1 (same-cycle drain and refill).
REQ-019 When the register can load, exactly one valid port gets ready=1; when it cannot, r0_ready=r1_ready=0.
REQ-020 Ready is combinational on valid, o_ready and state; valid never depends on ready.
REQ-021 Grant: one valid port wins. Both valid with FIXED_PRIO=1: port 0 wins. Both valid with FIXED_PRIO=0: the port not granted last wins.
REQ-022 last_grant updates only on an accepted handshake.
REQ-023 Latency: the result of a handshake in cycle N appears on o_y/o_ovf/o_zf/o_sf/o_id with o_valid=1 from cycle N+1.
REQ-024 Throughput: one result per cycle when o_ready stays 1.
REQ-025 Transitions: EMPTY->FULL on a handshake. FULL->EMPTY on o_ready with no handshake. FULL->FULL on o_ready with a handshake, or when o_ready=0.
REQ-026 While FULL and o_ready=0, o_y/o_ovf/o_zf/o_sf/o_id hold stable.
REQ-027 No request is dropped or duplicated; each handshake yields exactly one output transfer.
REQ-028 Requester may change ctrl/a/b while its ready=0; the block samples only on handshake.
REQ-029 o_zf/o_sf are computed from the registered o_y, not from a separate compare.

Reset
REQ-030 On rst_n low, asynchronously: state=EMPTY, o_valid=0, o_y=0, o_ovf=0, o_zf=0, o_sf=0, o_id=0, last_grant=1 (port 0 wins first round-robin tie).
REQ-031 During reset r0_ready=r1_ready=0.
REQ-032 Reset asserted mid-transfer discards any held result; no output transfer follows reset release without a new handshake.
REQ-033 First grant possible in the first rising edge after rst_n deasserts.

Verification
REQ-034 Port 0 add, a=0x7FFFFFFFFFFFFFFF, b=1, o_ready=1 -> next cycle o_valid=1, o_y=0x8000000000000000, o_ovf=1, o_sf=1, o_zf=0, o_id=0.
REQ-035 Port 1 sub, a=5, b=5 -> o_y=0, o_zf=1, o_ovf=0, o_id=1. Then xor a=0xFF, b=0x0F -> o_y=0xF0, o_ovf=0.
REQ-036 FIXED_PRIO=0, both ports valid continuously, o_ready=1, 6 cycles -> o_id sequence 0,1,0,1,0,1; one result per cycle.
REQ-037 o_ready=0 for 3 cycles while FULL with both ports valid -> r0_ready=r1_ready=0, o_y stable. o_ready=1 -> drain and refill in the same cycle, no bubble.
REQ-038 FIXED_PRIO=1, both ports valid for 4 cycles -> o_id=0 every cycle; port 1 granted only after r0_valid drops.
REQ-039 rst_n pulsed low while FULL with o_ready=0 -> o_valid=0 immediately (asynchronous), outputs zero; port 0 wins the first tie after release.

Source files
------------

// File: rtl/alu_arbiter.sv
// +--------------------------------------------------------------------------+
// | alu_arbiter: two-port arbiter feeding one shared 64-bit ALU into a        |
// | single registered result slot with valid/ready handshakes.               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module alu_arbiter #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        r0_valid,
    output logic        r0_ready,
    input  logic [1:0]  r0_ctrl,
    input  logic [63:0] r0_a,
    input  logic [63:0] r0_b,
    input  logic        r1_valid,
    output logic        r1_ready,
    input  logic [1:0]  r1_ctrl,
    input  logic [63:0] r1_a,
    input  logic [63:0] r1_b,
    output logic        o_valid,
    input  logic        o_ready,
    output logic [63:0] o_y,
    output logic        o_ovf,
    output logic        o_zf,
    output logic        o_sf,
    output logic        o_id
);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [1:0] C_OP_ADD = 2'b00;
    localparam logic [1:0] C_OP_SUB = 2'b01;
    localparam logic [1:0] C_OP_AND = 2'b10;
    localparam logic [1:0] C_OP_XOR = 2'b11;

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic [63:0] y_q, y_d;
    logic        ovf_q, ovf_d;
    logic        id_q, id_d;

    logic        w_can_load;
    logic        w_tie_pick;
    logic        w_hs;
    logic        w_sel;
    logic [1:0]  w_ctrl;
    logic [63:0] w_a;
    logic [63:0] w_b;
    logic [63:0] w_y;
    logic        w_ovf;

    // Ready is held low throughout reset even though state already reads EMPTY.
    always_comb begin
        w_can_load = rst_n && ((state_q == EMPTY) || o_ready);
        w_tie_pick = FIXED_PRIO ? 1'b0 : ~last_grant_q;
        r0_ready   = w_can_load && r0_valid && (!r1_valid || (w_tie_pick == 1'b0));
        r1_ready   = w_can_load && r1_valid && (!r0_valid || (w_tie_pick == 1'b1));
        w_hs       = r0_ready || r1_ready;
        w_sel      = r1_ready;
    end

    always_comb begin
        w_ctrl = w_sel ? r1_ctrl : r0_ctrl;
        w_a    = w_sel ? r1_a    : r0_a;
        w_b    = w_sel ? r1_b    : r0_b;
        w_y    = 64'd0;
        w_ovf  = 1'b0;
        case (w_ctrl)
            C_OP_ADD: begin
                w_y   = w_a + w_b;
                w_ovf = (w_a[63] == w_b[63]) && (w_y[63] != w_a[63]);
            end
            C_OP_SUB: begin
                w_y   = w_a - w_b;
                w_ovf = (w_a[63] != w_b[63]) && (w_y[63] != w_a[63]);
            end
            C_OP_AND: w_y = w_a & w_b;
            C_OP_XOR: w_y = w_a ^ w_b;
            default:  w_y = 64'd0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        y_d          = y_q;
        ovf_d        = ovf_q;
        id_d         = id_q;
        if (w_hs) begin
            state_d      = FULL;
            last_grant_d = w_sel;
            y_d          = w_y;
            ovf_d        = w_ovf;
            id_d         = w_sel;
        end else if (o_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            last_grant_q <= 1'b1;
            y_q          <= 64'd0;
            ovf_q        <= 1'b0;
            id_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            y_q          <= y_d;
            ovf_q        <= ovf_d;
            id_q         <= id_d;
        end
    end

    // Zero flag is qualified by occupancy so the cleared register does not report zero.
    assign o_valid = (state_q == FULL);
    assign o_y     = y_q;
    assign o_ovf   = ovf_q;
    assign o_zf    = (state_q == FULL) && (y_q == 64'd0);
    assign o_sf    = y_q[63];
    assign o_id    = id_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_alu_arbiter: directed self-checking bench for alu_arbiter, with one    |
// | round-robin and one fixed-priority instance sharing the same stimulus.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_alu_arbiter;

    logic        clk;
    logic        rst_n;
    logic        r0_valid, r1_valid;
    logic [1:0]  r0_ctrl, r1_ctrl;
    logic [63:0] r0_a, r0_b, r1_a, r1_b;
    logic        o_ready;

    logic        rr_r0_ready, rr_r1_ready, rr_o_valid, rr_o_ovf, rr_o_zf, rr_o_sf, rr_o_id;
    logic [63:0] rr_o_y;
    logic        fp_r0_ready, fp_r1_ready, fp_o_valid, fp_o_ovf, fp_o_zf, fp_o_sf, fp_o_id;
    logic [63:0] fp_o_y;

    int checks = 0;
    int errors = 0;

    alu_arbiter #(.FIXED_PRIO(1'b0)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(rr_r0_ready), .r0_ctrl(r0_ctrl), .r0_a(r0_a), .r0_b(r0_b),
        .r1_valid(r1_valid), .r1_ready(rr_r1_ready), .r1_ctrl(r1_ctrl), .r1_a(r1_a), .r1_b(r1_b),
        .o_valid(rr_o_valid), .o_ready(o_ready), .o_y(rr_o_y), .o_ovf(rr_o_ovf),
        .o_zf(rr_o_zf), .o_sf(rr_o_sf), .o_id(rr_o_id)
    );

    alu_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(fp_r0_ready), .r0_ctrl(r0_ctrl), .r0_a(r0_a), .r0_b(r0_b),
        .r1_valid(r1_valid), .r1_ready(fp_r1_ready), .r1_ctrl(r1_ctrl), .r1_a(r1_a), .r1_b(r1_b),
        .o_valid(fp_o_valid), .o_ready(o_ready), .o_y(fp_o_y), .o_ovf(fp_o_ovf),
        .o_zf(fp_o_zf), .o_sf(fp_o_sf), .o_id(fp_o_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n    = 1'b0;
        r0_valid = 1'b1;
        r1_valid = 1'b1;
        r0_ctrl  = 2'b00; r0_a = 64'd0; r0_b = 64'd0;
        r1_ctrl  = 2'b00; r1_a = 64'd0; r1_b = 64'd0;
        o_ready  = 1'b1;

        // Reset state, ready suppressed even with requests pending
        #3;
        chk("rst_o_valid", {63'd0, rr_o_valid}, 64'd0);
        chk("rst_o_y", rr_o_y, 64'd0);
        chk("rst_o_zf", {63'd0, rr_o_zf}, 64'd0);
        chk("rst_r0_ready", {63'd0, rr_r0_ready}, 64'd0);
        chk("rst_r1_ready", {63'd0, rr_r1_ready}, 64'd0);
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // Port 0 add with signed overflow
        r0_valid = 1'b1; r0_ctrl = 2'b00; r0_a = 64'h7FFF_FFFF_FFFF_FFFF; r0_b = 64'd1;
        #1;
        chk("add_r0_ready", {63'd0, rr_r0_ready}, 64'd1);
        chk("add_r1_ready", {63'd0, rr_r1_ready}, 64'd0);
        tick();
        r0_valid = 1'b0;
        chk("add_valid", {63'd0, rr_o_valid}, 64'd1);
        chk("add_y", rr_o_y, 64'h8000_0000_0000_0000);
        chk("add_ovf", {63'd0, rr_o_ovf}, 64'd1);
        chk("add_sf", {63'd0, rr_o_sf}, 64'd1);
        chk("add_zf", {63'd0, rr_o_zf}, 64'd0);
        chk("add_id", {63'd0, rr_o_id}, 64'd0);

        // Port 1 sub to zero, refilled in the cycle the previous result drains
        r1_valid = 1'b1; r1_ctrl = 2'b01; r1_a = 64'd5; r1_b = 64'd5;
        tick();
        chk("sub_valid", {63'd0, rr_o_valid}, 64'd1);
        chk("sub_y", rr_o_y, 64'd0);
        chk("sub_zf", {63'd0, rr_o_zf}, 64'd1);
        chk("sub_ovf", {63'd0, rr_o_ovf}, 64'd0);
        chk("sub_id", {63'd0, rr_o_id}, 64'd1);

        r1_ctrl = 2'b11; r1_a = 64'hFF; r1_b = 64'h0F;
        tick();
        chk("xor_y", rr_o_y, 64'hF0);
        chk("xor_ovf", {63'd0, rr_o_ovf}, 64'd0);
        chk("xor_zf", {63'd0, rr_o_zf}, 64'd0);

        r1_ctrl = 2'b10; r1_a = 64'hFFFF_0000_F0F0_1234; r1_b = 64'h8F00_FF00_FF00_0000;
        tick();
        chk("and_y", rr_o_y, 64'h8F00_0000_F000_0000);
        chk("and_sf", {63'd0, rr_o_sf}, 64'd1);
        chk("and_ovf", {63'd0, rr_o_ovf}, 64'd0);

        r1_ctrl = 2'b01; r1_a = 64'h8000_0000_0000_0000; r1_b = 64'd1;
        tick();
        chk("subovf_y", rr_o_y, 64'h7FFF_FFFF_FFFF_FFFF);
        chk("subovf_ovf", {63'd0, rr_o_ovf}, 64'd1);
        chk("subovf_sf", {63'd0, rr_o_sf}, 64'd0);

        // Drain with no new request empties the slot
        r1_valid = 1'b0;
        tick();
        chk("drain_valid", {63'd0, rr_o_valid}, 64'd0);

        // Round-robin alternation, last grant was port 1 so port 0 leads
        r0_valid = 1'b1; r0_ctrl = 2'b00; r0_a = 64'd1; r0_b = 64'd0;
        r1_valid = 1'b1; r1_ctrl = 2'b00; r1_a = 64'd2; r1_b = 64'd0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("rr_valid_%0d", i), {63'd0, rr_o_valid}, 64'd1);
            chk($sformatf("rr_id_%0d", i), {63'd0, rr_o_id}, 64'(i % 2));
            chk($sformatf("rr_y_%0d", i), rr_o_y, 64'((i % 2) + 1));
        end

        // Back-pressure: slot holds port 1's result (y=2)
        o_ready = 1'b0;
        #1;
        chk("bp_r0_ready", {63'd0, rr_r0_ready}, 64'd0);
        chk("bp_r1_ready", {63'd0, rr_r1_ready}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("bp_y_%0d", i), rr_o_y, 64'd2);
            chk($sformatf("bp_id_%0d", i), {63'd0, rr_o_id}, 64'd1);
            chk($sformatf("bp_valid_%0d", i), {63'd0, rr_o_valid}, 64'd1);
            chk($sformatf("bp_rdy_%0d", i), {62'd0, rr_r0_ready, rr_r1_ready}, 64'd0);
        end
        o_ready = 1'b1;
        #1;
        chk("refill_r0_ready", {63'd0, rr_r0_ready}, 64'd1);
        chk("refill_r1_ready", {63'd0, rr_r1_ready}, 64'd0);
        tick();
        chk("refill_valid", {63'd0, rr_o_valid}, 64'd1);
        chk("refill_id", {63'd0, rr_o_id}, 64'd0);
        chk("refill_y", rr_o_y, 64'd1);

        // Asynchronous reset while full and stalled
        o_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {63'd0, rr_o_valid}, 64'd0);
        chk("arst_y", rr_o_y, 64'd0);
        chk("arst_id", {63'd0, rr_o_id}, 64'd0);
        chk("arst_ovf", {63'd0, rr_o_ovf}, 64'd0);
        chk("arst_rdy", {62'd0, rr_r0_ready, rr_r1_ready}, 64'd0);
        #1;
        rst_n = 1'b1;
        o_ready = 1'b1;
        #1;
        chk("rel_r0_ready", {63'd0, rr_r0_ready}, 64'd1);
        chk("rel_r1_ready", {63'd0, rr_r1_ready}, 64'd0);
        tick();
        chk("rel_valid", {63'd0, rr_o_valid}, 64'd1);
        chk("rel_id", {63'd0, rr_o_id}, 64'd0);

        // Fixed priority instance: port 0 always wins while valid
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("fp_r1_ready_%0d", i), {63'd0, fp_r1_ready}, 64'd0);
            chk($sformatf("fp_id_%0d", i), {63'd0, fp_o_id}, 64'd0);
            chk($sformatf("fp_y_%0d", i), fp_o_y, 64'd1);
            tick();
        end
        r0_valid = 1'b0;
        #1;
        chk("fp_r1_ready_after", {63'd0, fp_r1_ready}, 64'd1);
        tick();
        chk("fp_id_after", {63'd0, fp_o_id}, 64'd1);
        chk("fp_y_after", fp_o_y, 64'd2);

        // Released reset without a request produces no transfer
        r1_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
        chk("idle_after_rst", {63'd0, rr_o_valid}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
